boreal_uart_rx: RTL
===================

// Module: boreal_uart_rx
// PURPOSE
//   Oversampling UART byte receiver (8N1, LSB first) for the Boreal host link.
//   Sits directly upstream of the host command decoder: turns the raw rx pin into
//   bytes on a valid/ready handshake and flags framing errors and overruns.
//   Frame assembly ([0xAA][CMD][AH][AL][DH][DL][CRC]) is done downstream, not here.
// PARAMETERS
//   CLK_FREQ    100_000_000  system clock frequency, Hz
//   BAUD_RATE   115_200      line rate, bit/s
//   OVERSAMPLE  16           ticks per bit; must be even and >= 4
//   (derived) DIV = (CLK_FREQ + BAUD_RATE*OVERSAMPLE/2) / (BAUD_RATE*OVERSAMPLE), rounded; must be >= 1
// PORTS
//   clk        in   1  system clock; all logic on posedge
//   rst        in   1  synchronous, active-high reset
//   rx         in   1  asynchronous serial input; idle high
//   rx_data    out  8  received byte; stable while rx_valid=1
//   rx_valid   out  1  byte available; held until it is accepted
//   rx_ready   in   1  consumer accepts the byte when rx_valid & rx_ready
//   frame_err  out  1  one-clk pulse: stop bit sampled low
//   overrun    out  1  one-clk pulse: a new byte was dropped because rx_valid was still held
// BEHAVIOUR
//   Reset: rx_data=0, rx_valid=0, frame_err=0, overrun=0. FSM=IDLE. Tick counter=0.
//     Both synchronizer flops reset to 1. Reset wins over every other event, including mid-byte.
//   Sync: rx passes through a 2-flop synchronizer (rx_s). The FSM uses only rx_s.
//   Tick: a free-running counter counts 0..DIV-1; tick=1 for one clk when it wraps.
//     The bit phase counter ph (0..OVERSAMPLE-1) advances only on tick.
//   FSM (state changes only on tick):
//     IDLE   : if rx_s==0 -> START with ph=0
//     START  : when ph==OVERSAMPLE/2-1 (mid start bit):
//                if rx_s==0 -> DATA with ph=0, bit=0
//                else -> IDLE (glitch rejected, no output)
//     DATA   : when ph==OVERSAMPLE-1: shift rx_s into sr[7] and shift right (LSB first), ph=0, bit++
//              after bit 7 -> STOP
//     STOP   : when ph==OVERSAMPLE-1:
//                if rx_s==1 -> deliver the byte, then IDLE
//                if rx_s==0 -> pulse frame_err, discard the byte, then BREAK
//     BREAK  : stay until rx_s==1 on a tick -> IDLE (a held-low line never produces bytes)
//   Delivery (on the clk after the stop-bit sample):
//     rx_valid==0, or rx_valid & rx_ready in the same clk -> load rx_data=sr and set rx_valid=1
//     rx_valid & !rx_ready -> keep the old byte, pulse overrun, drop the new byte
//   Handshake: while no delivery occurs, rx_valid & rx_ready clears rx_valid on the next clk.
//     rx_data stays unchanged while rx_valid=1. rx_ready has no effect while rx_valid=0.
//   Latency: rx_valid rises 1 clk after the tick that samples the stop bit
//     (about 9.5 bit times after the start edge, plus 2 clks of synchronizer delay).
//   frame_err and overrun are never asserted together.
//     Both drop back to 0 on the clk after their pulse.
// TESTING (bench: CLK_FREQ=6_400_000, BAUD_RATE=100_000, OVERSAMPLE=16 -> DIV=4, 64 clk/bit)
//   1. Reset, hold rx=1 for 1000 clk -> rx_valid, frame_err and overrun stay 0; rx_data=0.
//   2. Send 0xA5 then 0x3C with rx_ready=1 -> each gives exactly one rx_valid pulse,
//      rx_data=0xA5 then 0x3C, each about 608+2 clk after its start edge.
//   3. Drive rx low for 12 clk (<half a bit) then high -> no rx_valid; then send 0x55 -> receives 0x55.
//   4. Send 0x81 with the stop bit low, then hold rx=0 for 20 bits, then idle, then send 0x7E
//      -> one frame_err pulse, no byte from the break, then rx_data=0x7E.
//   5. rx_ready=0; send 0x11 then 0x22 -> rx_data stays 0x11 and overrun pulses once.
//      Repeat with rx_ready=1 in the delivery clk of 0x22 -> no overrun; 0x22 is presented.
//   6. Assert rst mid-DATA while sending 0xF0 -> all outputs reset. Release rst and send 0x0F
//      -> exactly one byte, 0x0F.

Source files
------------

// File: rtl/boreal_uart_rx.sv
// Oversampling 8N1 UART byte receiver (LSB first) with a valid/ready output,
// framing-error and overrun pulses, and break (held-low line) suppression.
module boreal_uart_rx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned DIV = (CLK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PW  = $clog2(OVERSAMPLE);

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [PW-1:0] PH_MID   = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sr_q, sr_d;
  logic          rx_m_q, rx_m_d;
  logic          rx_s_q, rx_s_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  logic tick;
  logic deliver;
  logic stop_bad;

  assign tick = (cnt_q == DIV_LAST);

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    bit_d       = bit_q;
    sr_d        = sr_q;
    cnt_d       = tick ? '0 : cnt_q + CW'(1);
    rx_m_d      = rx;
    rx_s_d      = rx_m_q;
    deliver     = 1'b0;
    stop_bad    = 1'b0;

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            ph_d    = '0;
          end
        end
        S_START: begin
          if (ph_q == PH_MID) begin
            if (!rx_s_q) begin
              state_d = S_DATA;
              ph_d    = '0;
              bit_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            ph_d = ph_q + PW'(1);
          end
        end
        S_DATA: begin
          if (ph_q == PH_LAST) begin
            sr_d  = {rx_s_q, sr_q[7:1]};
            ph_d  = '0;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_STOP;
          end else begin
            ph_d = ph_q + PW'(1);
          end
        end
        S_STOP: begin
          if (ph_q == PH_LAST) begin
            if (rx_s_q) begin
              deliver = 1'b1;
              state_d = S_IDLE;
            end else begin
              stop_bad = 1'b1;
              state_d  = S_BREAK;
            end
          end else begin
            ph_d = ph_q + PW'(1);
          end
        end
        S_BREAK: begin
          if (rx_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A delivery takes precedence over the plain handshake clear; accepting in
    // the same clk frees the slot so the new byte replaces the old one.
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = stop_bad;
    overrun_d   = 1'b0;
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = sr_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ph_q        <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      rx_m_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ph_q        <= ph_d;
      bit_q       <= bit_d;
      sr_q        <= sr_d;
      rx_m_q      <= rx_m_d;
      rx_s_q      <= rx_s_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
